// File: rtl/ahbl_pkg.sv
// AHB-Lite encodings and master FSM states shared by the SRAM initiator.
// Also holds the 1 KB boundary helper used for NONSEQ restarts.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_BURST = 3'd2,
        ST_LAST  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // An address landing on a 1 KB page start must restart as NONSEQ.
    function automatic logic kb_edge(input logic [9:0] a);
        return (a == 10'd0);
    endfunction

endpackage

// File: rtl/ahbl_sram_master.sv
// AHB-Lite initiator: turns one (addr, len, dir) command into a SINGLE/INCR
// word burst with wait-state, 1 KB boundary and two-cycle ERROR handling.
module ahbl_sram_master
    import ahbl_pkg::*;
#(
    parameter int AHB_AWIDTH = 32,
    parameter int AHB_DWIDTH = 32,
    parameter int LEN_W      = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [AHB_AWIDTH-1:0] cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [AHB_DWIDTH-1:0] wr_data,
    output logic                  wr_pop,
    output logic [AHB_DWIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  err,
    output logic [AHB_AWIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [AHB_DWIDTH-1:0] HWDATA,
    input  logic [AHB_DWIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic [1:0]            HRESP
);

    localparam logic [AHB_AWIDTH-1:0] STEP  = AHB_AWIDTH'(4);
    localparam logic [AHB_AWIDTH-1:0] ALIGN = ~AHB_AWIDTH'(3);
    localparam logic [LEN_W-1:0]      ONE   = LEN_W'(1);

    state_t state_q, state_d;

    logic [LEN_W-1:0]      rem_addr_q;
    logic [LEN_W-1:0]      rem_data_q;
    logic [AHB_AWIDTH-1:0] addr_q;
    logic                  dp_valid_q;
    logic                  write_q;
    logic [2:0]            burst_q;
    logic [2:0]            size_q;
    logic [AHB_DWIDTH-1:0] wdata_q;
    logic [AHB_DWIDTH-1:0] rdata_q;
    logic                  rvalid_q;
    logic                  done_q;
    logic                  err_q;

    logic load;
    logic addr_acc;
    logic dp_done;
    logic dp_err;
    logic fin_ok;
    logic fin_err;

    assign load     = (state_q == ST_IDLE) && cmd_valid && (cmd_len != '0);
    assign addr_acc = HREADY && ((state_q == ST_ADDR) || (state_q == ST_BURST));
    assign dp_done  = dp_valid_q && HREADY;
    // First cycle of a two-cycle ERROR: slave stalls while flagging it.
    assign dp_err   = dp_valid_q && !HREADY && (HRESP == HRESP_ERROR);

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= fin_ok | fin_err;
            err_q   <= fin_err;
        end
    end

    always_comb begin
        state_d = state_q;
        fin_ok  = 1'b0;
        fin_err = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        state_d = ST_ADDR;
                    end else begin
                        fin_ok = 1'b1;
                    end
                end
            end
            ST_ADDR, ST_BURST: begin
                if (dp_err) begin
                    state_d = ST_ERR;
                end else if (addr_acc) begin
                    state_d = (rem_addr_q > ONE) ? ST_BURST : ST_LAST;
                end
            end
            ST_LAST: begin
                if (dp_err) begin
                    state_d = ST_ERR;
                end else if (dp_done && (rem_data_q == ONE)) begin
                    state_d = ST_IDLE;
                    fin_ok  = 1'b1;
                end
            end
            ST_ERR: begin
                if (HREADY) begin
                    state_d = ST_IDLE;
                    fin_err = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        HTRANS    = HTRANS_IDLE;
        unique case (state_q)
            ST_IDLE:  cmd_ready = 1'b1;
            ST_ADDR:  HTRANS = HTRANS_NONSEQ;
            ST_BURST: HTRANS = kb_edge(addr_q[9:0]) ? HTRANS_NONSEQ
                                                    : HTRANS_SEQ;
            default:  HTRANS = HTRANS_IDLE;
        endcase
    end

    assign wr_pop = addr_acc && write_q;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            addr_q     <= '0;
            rem_addr_q <= '0;
            rem_data_q <= '0;
            write_q    <= 1'b0;
            burst_q    <= HBURST_SINGLE;
            size_q     <= 3'b000;
            wdata_q    <= '0;
            dp_valid_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rvalid_q <= 1'b0;
            if (load) begin
                addr_q     <= cmd_addr & ALIGN;
                rem_addr_q <= cmd_len;
                write_q    <= cmd_write;
                burst_q    <= (cmd_len == ONE) ? HBURST_SINGLE : HBURST_INCR;
                size_q     <= HSIZE_WORD;
            end else if (addr_acc) begin
                addr_q     <= addr_q + STEP;
                rem_addr_q <= rem_addr_q - ONE;
            end
            if (addr_acc && write_q) begin
                wdata_q <= wr_data;
            end
            if (load) begin
                rem_data_q <= cmd_len;
            end else if (dp_done) begin
                rem_data_q <= rem_data_q - ONE;
            end
            if (addr_acc) begin
                dp_valid_q <= 1'b1;
            end else if (HREADY) begin
                dp_valid_q <= 1'b0;
            end
            if (dp_done && !write_q && (HRESP == HRESP_OKAY)) begin
                rvalid_q <= 1'b1;
                rdata_q  <= HRDATA;
            end
        end
    end

    assign HADDR    = addr_q;
    assign HWRITE   = write_q;
    assign HSIZE    = size_q;
    assign HBURST   = burst_q;
    assign HWDATA   = wdata_q;
    assign rd_data  = rdata_q;
    assign rd_valid = rvalid_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ahbl_sram_master.sv
// Bench: master + behavioural SRAM slave with random waits and error beat,
// checked against a command-level model of bus beats and memory contents.
module tb_ahbl_sram_master;
    import ahbl_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETN;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data, rd_data;
    logic        wr_pop, rd_valid, done, err;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS, HRESP;
    logic        HWRITE, HREADY;
    logic [2:0]  HSIZE, HBURST;

    always #5 HCLK = ~HCLK;

    ahbl_sram_master #(.AHB_AWIDTH(32), .AHB_DWIDTH(32), .LEN_W(8)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_pop(wr_pop),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    // ---------------- slave model ----------------
    logic [31:0] mem [0:1023];
    logic        s_act = 1'b0, s_wr = 1'b0, s_err = 1'b0;
    logic [9:0]  s_idx = '0;
    int          s_wait = 0;
    int          beat = 0;
    int          max_wait = 0;
    int          err_abs = -1;

    assign HREADY = !s_act || (s_wait == 0);
    assign HRESP  = (s_act && s_err) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA = s_act ? mem[s_idx] : 32'h0;

    always @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            s_act  <= 1'b0;
            s_err  <= 1'b0;
            s_wait <= 0;
        end else if (s_act && s_wait != 0) begin
            s_wait <= s_wait - 1;
        end else begin
            if (s_act && s_wr && !s_err) mem[s_idx] <= HWDATA;
            if (HTRANS[1]) begin
                s_act  <= 1'b1;
                s_idx  <= HADDR[11:2];
                s_wr   <= HWRITE;
                s_err  <= (beat == err_abs);
                s_wait <= (beat == err_abs) ? 1 : int'($urandom_range(max_wait, 0));
                beat   <= beat + 1;
            end else begin
                s_act <= 1'b0;
            end
        end
    end

    // ---------------- write source ----------------
    logic [31:0] wsrc [0:511];
    int          pop_total = 0;
    assign wr_data = wsrc[pop_total[8:0]];
    always @(posedge HCLK) if (wr_pop) pop_total <= pop_total + 1;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    logic [31:0] a_addr [0:2047];
    logic [1:0]  a_tr   [0:2047];
    logic [2:0]  a_bu   [0:2047];
    logic [2:0]  a_sz   [0:2047];
    logic        a_wr   [0:2047];
    logic [31:0] r_dat  [0:2047];
    int          a_n = 0, r_n = 0, stab_bad = 0, e_cnt = 0;
    logic [1:0]  e_trans = 2'b11;
    logic        p_rdy = 1'b1, p_ok = 1'b1, p_ef = 1'b0;
    logic [1:0]  p_tr = '0;
    logic [31:0] p_ad = '0, p_wd = '0;

    always @(negedge HCLK) begin
        if (!HRESETN) begin
            p_rdy <= 1'b1;
            p_ef  <= 1'b0;
        end else begin
            if (HREADY && HTRANS != HTRANS_IDLE) begin
                a_addr[a_n % 2048] <= HADDR;
                a_tr[a_n % 2048]   <= HTRANS;
                a_bu[a_n % 2048]   <= HBURST;
                a_sz[a_n % 2048]   <= HSIZE;
                a_wr[a_n % 2048]   <= HWRITE;
                a_n <= a_n + 1;
            end
            if (rd_valid) begin
                r_dat[r_n % 2048] <= rd_data;
                r_n <= r_n + 1;
            end
            if (!p_rdy && p_ok &&
                (HWDATA !== p_wd ||
                 (p_tr != HTRANS_IDLE && (HADDR !== p_ad || HTRANS !== p_tr))))
                stab_bad <= stab_bad + 1;
            if (p_ef) begin
                e_trans <= HTRANS;
                e_cnt   <= e_cnt + 1;
            end
            p_ef  <= (HRESP == HRESP_ERROR) && !HREADY;
            p_rdy <= HREADY;
            p_ok  <= (HRESP == HRESP_OKAY);
            p_tr  <= HTRANS;
            p_ad  <= HADDR;
            p_wd  <= HWDATA;
        end
    end

    // ---------------- checking ----------------
    logic [31:0] ref_mem [0:1023];
    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_rand(input int len);
        for (int i = 0; i < len; i++) wsrc[(pop_total + i) % 512] = $urandom;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input int len,
                         output logic ok, output int lat, output logic e,
                         output int a0, output int r0, output int p0);
        int t_acc, n;
        @(negedge HCLK);
        a0 = a_n; r0 = r_n; p0 = pop_total;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len[7:0];
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge HCLK); n++; end
        t_acc = cyc;
        @(negedge HCLK);
        cmd_valid = 1'b0;
        n = 0;
        while (!done && n < 1000) begin @(negedge HCLK); n++; end
        ok = done; lat = cyc - t_acc; e = err;
        repeat (2) @(negedge HCLK);
    endtask

    task automatic run_cmd(input string tag, input logic wr, input logic [31:0] addr,
                           input int len, input int maxw);
        int lat, a0, r0, p0, bad, idx;
        logic ok, e;
        logic [31:0] base, ea;
        logic [1:0] etr;
        max_wait = maxw; err_abs = -1;
        issue(wr, addr, len, ok, lat, e, a0, r0, p0);
        check({tag, "_done"}, ok, 1);
        check({tag, "_err"}, e, 0);
        if (maxw == 0) check({tag, "_lat"}, lat, (len == 0) ? 1 : len + 2);
        check({tag, "_nph"}, a_n - a0, len);
        base = addr & 32'hFFFF_FFFC;
        bad = 0;
        for (int i = 0; i < len; i++) begin
            ea  = base + 32'(4 * i);
            etr = (i == 0 || ea[9:0] == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            idx = (a0 + i) % 2048;
            if (a_addr[idx] !== ea || a_tr[idx] !== etr || a_sz[idx] !== HSIZE_WORD ||
                a_wr[idx] !== wr ||
                a_bu[idx] !== ((len == 1) ? HBURST_SINGLE : HBURST_INCR)) bad++;
        end
        check({tag, "_phases"}, bad, 0);
        bad = 0;
        if (wr) begin
            check({tag, "_pops"}, pop_total - p0, len);
            for (int i = 0; i < len; i++) begin
                ea = base + 32'(4 * i);
                ref_mem[ea[11:2]] = wsrc[(p0 + i) % 512];
            end
        end else begin
            check({tag, "_nopop"}, pop_total - p0, 0);
            check({tag, "_nrd"}, r_n - r0, len);
            for (int i = 0; i < len; i++) begin
                ea = base + 32'(4 * i);
                if (r_dat[(r0 + i) % 2048] !== ref_mem[ea[11:2]]) bad++;
            end
            check({tag, "_rdata"}, bad, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, a0, r0, p0, e0;
        logic ok, e;
        logic [31:0] ra;
        int rl;

        HRESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_len = '0;
        for (int i = 0; i < 512; i++) wsrc[i] = 32'h0;
        repeat (2) @(negedge HCLK);
        check("rst_ready", cmd_ready, 1);
        check("rst_bus", {HADDR, HTRANS, HWRITE, HSIZE, HBURST}, 0);
        check("rst_misc", {HWDATA, rd_valid, done, err, wr_pop}, 0);
        check("rst_rdata", rd_data, 0);
        HRESETN = 1'b1;
        repeat (2) @(negedge HCLK);

        // single write then read
        wsrc[pop_total % 512] = 32'hDEAD_BEEF;
        run_cmd("t1w", 1'b1, 32'h100, 1, 0);
        run_cmd("t1r", 1'b0, 32'h100, 1, 0);
        check("t1_rd", r_dat[(r_n - 1) % 2048], 32'hDEAD_BEEF);

        // 16-beat burst, data = index
        for (int i = 0; i < 16; i++) wsrc[(pop_total + i) % 512] = i;
        run_cmd("t2w", 1'b1, 32'h0, 16, 0);
        run_cmd("t2r", 1'b0, 32'h0, 16, 0);
        check("t2_rd15", r_dat[(r_n - 1) % 2048], 15);

        // random waits
        fill_rand(8);
        run_cmd("t3w", 1'b1, 32'h240, 8, 3);
        run_cmd("t3r", 1'b0, 32'h240, 8, 3);
        check("t3_stable", stab_bad, 0);

        // 1 KB boundary
        fill_rand(4);
        run_cmd("t4w", 1'b1, 32'h3F8, 4, 0);
        check("t4_addr2", a_addr[(a_n - 2) % 2048], 32'h400);
        check("t4_tr2", a_tr[(a_n - 2) % 2048], HTRANS_NONSEQ);
        run_cmd("t4r", 1'b0, 32'h3F8, 4, 0);

        // address wrap at top of space
        fill_rand(2);
        run_cmd("twrap_w", 1'b1, 32'hFFFF_FFFE, 2, 0);
        run_cmd("twrap_r", 1'b0, 32'hFFFF_FFFC, 2, 0);

        // zero-length command
        run_cmd("tzero", 1'b0, 32'h80, 0, 0);

        // ERROR on third beat of a read
        fill_rand(8);
        run_cmd("t5w", 1'b1, 32'h200, 8, 0);
        max_wait = 0; err_abs = beat + 2; e0 = e_cnt;
        issue(1'b0, 32'h200, 8, ok, lat, e, a0, r0, p0);
        err_abs = -1;
        check("t5_done", ok, 1);
        check("t5_err", e, 1);
        check("t5_nrd", r_n - r0, 2);
        check("t5_rd0", r_dat[r0 % 2048], ref_mem[10'h80]);
        check("t5_rd1", r_dat[(r0 + 1) % 2048], ref_mem[10'h81]);
        check("t5_idle", e_trans, HTRANS_IDLE);
        check("t5_ecnt", e_cnt - e0, 1);
        check("t5_nph", a_n - a0, 3);

        // random write/read-back pairs
        for (int k = 0; k < 8; k++) begin
            ra = $urandom & 32'h0000_0FFF;
            rl = int'($urandom_range(20, 1));
            fill_rand(rl);
            run_cmd($sformatf("rnd%0dw", k), 1'b1, ra, rl, k % 4);
            run_cmd($sformatf("rnd%0dr", k), 1'b0, ra, rl, (k + 1) % 4);
        end

        // reset mid-burst, then zero-length command
        max_wait = 0; err_abs = -1;
        fill_rand(16);
        @(negedge HCLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h500; cmd_len = 8'd16;
        @(negedge HCLK);
        cmd_valid = 1'b1; cmd_len = 8'd3;
        repeat (5) @(negedge HCLK);
        check("t6_busy_tr", HTRANS, HTRANS_SEQ);
        check("t6_busy_rdy", cmd_ready, 0);
        cmd_valid = 1'b0;
        #2 HRESETN = 1'b0;
        #1;
        check("t6_rst_tr", HTRANS, HTRANS_IDLE);
        check("t6_rst_rdy", cmd_ready, 1);
        check("t6_rst_out", {HADDR, wr_pop, done, HWDATA}, 0);
        repeat (2) @(negedge HCLK);
        HRESETN = 1'b1;
        #1;
        check("t6_rel", {cmd_ready, HTRANS}, {1'b1, HTRANS_IDLE});
        run_cmd("t6z", 1'b0, 32'h500, 0, 0);

        check("stable_all", stab_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
